// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier family: digit codes and FSM states.
package booth_pkg;

   // Digit code: bit2 = negate, bit1 = use 2*A, bit0 = use A
   localparam logic [2:0] DIG_ZERO = 3'b000;
   localparam logic [2:0] DIG_POS1 = 3'b001;
   localparam logic [2:0] DIG_POS2 = 3'b010;
   localparam logic [2:0] DIG_NEG1 = 3'b101;
   localparam logic [2:0] DIG_NEG2 = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/booth_r4_digit.sv
// Radix-4 Booth recoder: one overlapping 3-bit multiplier window -> one digit code.
module booth_r4_digit
   import booth_pkg::*;
(
   input  logic [2:0] window_i,
   output logic [2:0] digit_o
);

   // Window {b[2i+1], b[2i], b[2i-1]} maps to a digit in {-2,-1,0,+1,+2}
   always_comb begin
      digit_o = DIG_ZERO;
      case (window_i)
         3'b001, 3'b010: digit_o = DIG_POS1;
         3'b011:         digit_o = DIG_POS2;
         3'b100:         digit_o = DIG_NEG2;
         3'b101, 3'b110: digit_o = DIG_NEG1;
         default:        digit_o = DIG_ZERO;
      endcase
   end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, ready/valid on both sides.
// The multiplicand is pre-shifted by 2 each cycle and the multiplier shifted right by 2,
// so the recoder always looks at the low three bits of the multiplier register.
module booth_r4_seq_mult
   import booth_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter bit SIGNED = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   // Unsigned operands need one extra digit so the top window sees zero sign bits
   localparam int N  = SIGNED ? WIDTH / 2 : WIDTH / 2 + 1;
   localparam int BW = 2 * N;
   localparam int AW = 2 * WIDTH + 2;
   localparam int CW = $clog2(N + 1);

   state_t             state_q, state_d;
   logic [AW-1:0]      acc_q, acc_d;
   logic [AW-1:0]      mcand_q, mcand_d;
   logic [BW:0]        mplier_q, mplier_d;   // bit 0 holds b[2i-1]
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] product_q, product_d;

   logic [AW-1:0]      mcand_ext;
   logic [BW-1:0]      mplier_ext;
   logic [2:0]         digit;
   logic [AW-1:0]      pp_mag;
   logic [AW-1:0]      pp;
   logic [AW-1:0]      acc_sum;

   // Sign-extend A only in signed mode; B is zero-extended to the full digit span
   assign mcand_ext  = {{(AW - WIDTH){multiplicand[WIDTH-1] & SIGNED}}, multiplicand};
   assign mplier_ext = BW'(multiplier);

   booth_r4_digit u_digit (
      .window_i (mplier_q[2:0]),
      .digit_o  (digit)
   );

   // Partial product: select 0, A or 2A, then two's-complement negate when requested
   always_comb begin
      pp_mag = '0;
      if (digit[1]) begin
         pp_mag = mcand_q << 1;
      end else if (digit[0]) begin
         pp_mag = mcand_q;
      end
      pp      = digit[2] ? (~pp_mag + AW'(1)) : pp_mag;
      acc_sum = acc_q + pp;
   end

   // Next-state and datapath updates for IDLE / RUN / DONE
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               mcand_d  = mcand_ext;
               mplier_d = {mplier_ext, 1'b0};
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 2;
            mplier_d = mplier_q >> 2;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
               product_d = acc_sum[2*WIDTH-1:0];
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               product_d = '0;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            product_d = '0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign product   = product_q;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Bench for booth_r4_seq_mult: six instances (WIDTH 4/8/16, signed and unsigned),
// directed corner cases plus randomized traffic against an arithmetic reference.
module tb_booth_r4_seq_mult;

   localparam int NCFG = 6;

   logic            clk;
   logic            rst;
   logic [NCFG-1:0] in_valid;
   logic [NCFG-1:0] out_ready;
   logic [15:0]     mc [NCFG];
   logic [15:0]     mp [NCFG];
   wire  [NCFG-1:0] in_ready;
   wire  [NCFG-1:0] out_valid;
   wire  [NCFG-1:0] busy;
   wire  [31:0]     prod [NCFG];

   int checks = 0;
   int fails  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Config k: WIDTH = 4 << (k/2), SIGNED for even k
   for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
      localparam int W = 4 << (gi / 2);
      localparam bit S = ((gi % 2) == 0);
      wire [2*W-1:0] p;
      booth_r4_seq_mult #(.WIDTH(W), .SIGNED(S)) u_dut (
         .clk          (clk),
         .rst          (rst),
         .in_valid     (in_valid[gi]),
         .in_ready     (in_ready[gi]),
         .multiplicand (mc[gi][W-1:0]),
         .multiplier   (mp[gi][W-1:0]),
         .out_valid    (out_valid[gi]),
         .out_ready    (out_ready[gi]),
         .product      (p),
         .busy         (busy[gi])
      );
      assign prod[gi] = 32'(p);
   end

   function automatic int cfg_w(input int k);
      return 4 << (k / 2);
   endfunction

   function automatic bit cfg_s(input int k);
      return (k % 2) == 0;
   endfunction

   function automatic int cfg_n(input int k);
      return cfg_s(k) ? cfg_w(k) / 2 : cfg_w(k) / 2 + 1;
   endfunction

   // Reference: interpret operands as W-bit signed/unsigned integers and multiply
   function automatic logic [31:0] ref_mult(input int k, input logic [15:0] a, input logic [15:0] b);
      int     w;
      longint m, av, bv;
      w  = cfg_w(k);
      m  = (longint'(1) << w) - 1;
      av = longint'(a) & m;
      bv = longint'(b) & m;
      if (cfg_s(k)) begin
         if (((av >> (w - 1)) & 1) != 0) av = av - (longint'(1) << w);
         if (((bv >> (w - 1)) & 1) != 0) bv = bv - (longint'(1) << w);
      end
      return 32'((av * bv) & ((longint'(1) << (2 * w)) - 1));
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present an operand pair once in_ready is seen; scramble inputs after acceptance
   task automatic launch(input int k, input logic [15:0] a, input logic [15:0] b, output bit ok);
      int n;
      n  = 0;
      ok = 1'b0;
      while (!in_ready[k] && n < 50) begin
         step();
         n++;
      end
      if (in_ready[k]) begin
         mc[k]       = a;
         mp[k]       = b;
         in_valid[k] = 1'b1;
         step();
         in_valid[k] = 1'b0;
         mc[k]       = 16'($urandom);
         mp[k]       = 16'($urandom);
         ok          = 1'b1;
      end
   endtask

   task automatic wait_out(input int k, output int edges);
      edges = 0;
      while (!out_valid[k] && edges < 64) begin
         step();
         edges++;
      end
      if (!out_valid[k]) edges = -1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #2 rst = 1'b1;
      step();
      step();
      for (int k = 0; k < NCFG; k++) begin
         checks++; if (in_ready[k] !== 1'b1) begin fails++; $display("FAIL reset_in_ready cfg=%0d got=%b want=1", k, in_ready[k]); end
         checks++; if (out_valid[k] !== 1'b0) begin fails++; $display("FAIL reset_out_valid cfg=%0d got=%b want=0", k, out_valid[k]); end
         checks++; if (busy[k] !== 1'b0) begin fails++; $display("FAIL reset_busy cfg=%0d got=%b want=0", k, busy[k]); end
         checks++; if (prod[k] !== 32'h0) begin fails++; $display("FAIL reset_product cfg=%0d got=%h want=0", k, prod[k]); end
      end
      rst = 1'b0;
      step();
   endtask

   // One operation with out_ready held high: latency, product and release behaviour
   task automatic test_directed(input int k, input logic [15:0] a, input logic [15:0] b, input logic [31:0] expv);
      bit ok;
      int edges;
      out_ready[k] = 1'b1;
      launch(k, a, b, ok);
      checks++; if (!ok) begin fails++; $display("FAIL accept cfg=%0d got=no_accept want=accept", k); end
      wait_out(k, edges);
      checks++; if (edges != cfg_n(k)) begin fails++; $display("FAIL latency cfg=%0d got=%0d want=%0d", k, edges, cfg_n(k)); end
      checks++; if (prod[k] !== expv) begin fails++; $display("FAIL product cfg=%0d a=%h b=%h got=%h want=%h", k, a, b, prod[k], expv); end
      $display("txn cfg=%0d a=%h b=%h product=%h edges=%0d", k, a, b, prod[k], edges);
      step();
      checks++; if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || prod[k] !== 32'h0) begin
         fails++; $display("FAIL release cfg=%0d got=rdy%b/vld%b/%h want=rdy1/vld0/0", k, in_ready[k], out_valid[k], prod[k]);
      end
   endtask

   task automatic test_signed_basic();
      test_directed(2, 16'd7, 16'hFFFD, 32'h0000FFEB);
   endtask

   task automatic test_signed_corners();
      test_directed(2, 16'h0080, 16'h0080, 32'h00004000);
      test_directed(2, 16'h0080, 16'h007F, 32'h0000C080);
   endtask

   task automatic test_unsigned();
      test_directed(3, 16'd255, 16'd255, 32'h0000FE01);
      test_directed(3, 16'd0, 16'd200, 32'h00000000);
   endtask

   task automatic test_backpressure();
      bit          ok;
      int          edges;
      int          stray;
      logic [15:0] a, b;
      logic [31:0] expv;
      a    = 16'($urandom);
      b    = 16'($urandom);
      expv = ref_mult(2, a, b);
      out_ready[2] = 1'b0;
      launch(2, a, b, ok);
      wait_out(2, edges);
      checks++; if (edges != 4) begin fails++; $display("FAIL bp_latency got=%0d want=4", edges); end
      checks++; if (prod[2] !== expv) begin fails++; $display("FAIL bp_product got=%h want=%h", prod[2], expv); end
      for (int i = 0; i < 10; i++) begin
         in_valid[2] = 1'b1;
         mc[2] = 16'($urandom);
         mp[2] = 16'($urandom);
         step();
         checks++; if (out_valid[2] !== 1'b1 || prod[2] !== expv || in_ready[2] !== 1'b0) begin
            fails++; $display("FAIL bp_hold cyc=%0d got=vld%b/rdy%b/%h want=vld1/rdy0/%h", i, out_valid[2], in_ready[2], prod[2], expv);
         end
      end
      in_valid[2]  = 1'b0;
      out_ready[2] = 1'b1;
      step();
      checks++; if (out_valid[2] !== 1'b0 || busy[2] !== 1'b0) begin
         fails++; $display("FAIL bp_release got=vld%b/busy%b want=vld0/busy0", out_valid[2], busy[2]);
      end
      stray = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (out_valid[2] || busy[2]) stray++;
      end
      checks++; if (stray != 0) begin fails++; $display("FAIL bp_stray_accept got=%0d want=0", stray); end
      $display("txn cfg=2 a=%h b=%h product=%h backpressure", a, b, expv);
   endtask

   task automatic test_reset_mid_run();
      bit ok;
      out_ready[2] = 1'b1;
      launch(2, 16'h00B7, 16'h0065, ok);
      step();
      step();
      rst = 1'b1;
      #1;
      checks++; if (in_ready[2] !== 1'b1 || out_valid[2] !== 1'b0 || prod[2] !== 32'h0 || busy[2] !== 1'b0) begin
         fails++; $display("FAIL reset_mid_run got=rdy%b/vld%b/busy%b/%h want=rdy1/vld0/busy0/0", in_ready[2], out_valid[2], busy[2], prod[2]);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      test_directed(2, 16'd3, 16'd5, 32'd15);
   endtask

   // Random traffic with random valid/ready gaps; expected products queued in accept order
   task automatic test_random(input int k, input int nops);
      logic [31:0] exp_q[$];
      logic [31:0] expv, held;
      logic [15:0] m;
      int          sent, recv, cyc;
      bit          accepted, stalled;
      m       = 16'((32'd1 << cfg_w(k)) - 1);
      sent    = 0;
      recv    = 0;
      cyc     = 0;
      stalled = 1'b0;
      held    = '0;
      while ((recv < nops || sent < nops) && cyc < nops * 40) begin
         if (stalled) begin
            checks++; if (out_valid[k] !== 1'b1 || prod[k] !== held) begin
               fails++; $display("FAIL rnd_stall cfg=%0d got=vld%b/%h want=vld1/%h", k, out_valid[k], prod[k], held);
            end
         end
         if (!in_valid[k] && sent < nops && $urandom_range(0, 3) != 0) begin
            mc[k]       = 16'($urandom) & m;
            mp[k]       = 16'($urandom) & m;
            in_valid[k] = 1'b1;
         end
         out_ready[k] = ($urandom_range(0, 2) != 0);
         accepted = 1'b0;
         if (in_valid[k] && in_ready[k]) begin
            exp_q.push_back(ref_mult(k, mc[k], mp[k]));
            sent++;
            accepted = 1'b1;
         end
         if (out_valid[k] && out_ready[k]) begin
            checks++;
            if (exp_q.size() == 0) begin
               fails++; $display("FAIL rnd_extra cfg=%0d got=%h want=no_result", k, prod[k]);
            end else begin
               expv = exp_q.pop_front();
               if (prod[k] !== expv) begin
                  fails++; $display("FAIL rnd_product cfg=%0d got=%h want=%h", k, prod[k], expv);
               end
               $display("txn cfg=%0d product=%h", k, prod[k]);
            end
            recv++;
         end
         stalled = out_valid[k] && !out_ready[k];
         held    = prod[k];
         step();
         if (accepted) in_valid[k] = 1'b0;
         cyc++;
      end
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      checks++; if (recv != nops || sent != nops || exp_q.size() != 0) begin
         fails++; $display("FAIL rnd_count cfg=%0d got=sent%0d/recv%0d/left%0d want=%0d each", k, sent, recv, exp_q.size(), nops);
      end
   endtask

   initial begin
      in_valid  = '0;
      out_ready = '0;
      for (int k = 0; k < NCFG; k++) begin
         mc[k] = '0;
         mp[k] = '0;
      end
      test_reset();
      test_signed_basic();
      test_signed_corners();
      test_unsigned();
      test_backpressure();
      test_reset_mid_run();
      for (int k = 0; k < NCFG; k++) test_random(k, 250);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
